administrador_de_salidas: RTL and testbench

//   Output manager of the MicroUAZ datapath. It sits between the register

---
 rtl/administrador_de_salidas_if.sv | 22 ++
 rtl/administrador_de_salidas.sv | 44 ++++
 tb/tb_administrador_de_salidas.sv | 87 ++++++++
 3 files changed

// File: rtl/administrador_de_salidas_if.sv
// administrador_de_salidas_if: operand/selection inputs and memory-bus outputs of the output manager
interface administrador_de_salidas_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 3
);
    logic [IDX_W-1:0]  RY;
    logic [DATA_W-1:0] RX;
    logic [IDX_W-1:0]  Num;
    logic [1:0]        Sel_Salidas;
    logic [DATA_W-1:0] o_Dataout;
    logic [ADDR_W-1:0] o_Addressdata;
    logic              ReadWrite;
    modport master (
        output RY, RX, Num, Sel_Salidas,
        input  o_Dataout, o_Addressdata, ReadWrite
    );
    modport slave (
        input  RY, RX, Num, Sel_Salidas,
        output o_Dataout, o_Addressdata, ReadWrite
    );
endinterface

// File: rtl/administrador_de_salidas.sv
// administrador_de_salidas: registered data/address/strobe driver for the MicroUAZ memory/IO bus
module administrador_de_salidas #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 3
) (
    input logic                    i_clk,
    input logic                    i_rst,
    administrador_de_salidas_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        STORE_REG = 2'b01,
        STORE_IMM = 2'b10,
        LOAD      = 2'b11
    } sel_t;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_Dataout     <= '0;
            bus.o_Addressdata <= '0;
            bus.ReadWrite     <= 1'b0;
        end else begin
            // case (not a ternary chain) so an unknown code falls to the idle default
            case (bus.Sel_Salidas)
                STORE_REG: begin
                    bus.o_Addressdata <= ADDR_W'(bus.RY);
                    bus.o_Dataout     <= bus.RX;
                    bus.ReadWrite     <= 1'b1;
                end
                STORE_IMM: begin
                    bus.o_Addressdata <= ADDR_W'(bus.Num);
                    bus.o_Dataout     <= bus.RX;
                    bus.ReadWrite     <= 1'b1;
                end
                LOAD: begin
                    bus.o_Addressdata <= ADDR_W'({bus.RY, bus.Num});
                    bus.o_Dataout     <= '0;
                    bus.ReadWrite     <= 1'b0;
                end
                default: bus.ReadWrite <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_administrador_de_salidas.sv
// tb_administrador_de_salidas: directed and random checks against a behavioural bus model
module tb_administrador_de_salidas;
    logic i_clk = 1'b0;
    logic i_rst;
    int compared = 0;
    int mismatched = 0;
    int exp_d, exp_a, exp_rw;
    administrador_de_salidas_if #(.DATA_W(8), .ADDR_W(8), .IDX_W(3)) bus ();
    administrador_de_salidas #(.DATA_W(8), .ADDR_W(8), .IDX_W(3)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus.slave)
    );
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Model: address is the register index, the immediate, or index*8+immediate for a load.
    task automatic step(input int rst, input int sel, input int ry, input int rx, input int num, input string tag);
        @(negedge i_clk);
        i_rst = rst[0];
        bus.Sel_Salidas = sel[1:0];
        bus.RY = ry[2:0];
        bus.RX = rx[7:0];
        bus.Num = num[2:0];
        @(posedge i_clk);
        #1;
        if (rst != 0) begin
            exp_d = 0; exp_a = 0; exp_rw = 0;
        end else if (sel == 1) begin
            exp_a = ry; exp_d = rx; exp_rw = 1;
        end else if (sel == 2) begin
            exp_a = num; exp_d = rx; exp_rw = 1;
        end else if (sel == 3) begin
            exp_a = ry * 8 + num; exp_d = 0; exp_rw = 0;
        end else begin
            exp_rw = 0;
        end
        check({tag, ".data"}, int'(bus.o_Dataout), exp_d);
        check({tag, ".addr"}, int'(bus.o_Addressdata), exp_a);
        check({tag, ".rw"}, int'(bus.ReadWrite), exp_rw);
    endtask

    initial begin
        i_rst = 1'b1;
        bus.Sel_Salidas = 2'b01;
        bus.RY = 3'd7;
        bus.RX = 8'hAA;
        bus.Num = 3'd7;
        exp_d = 0; exp_a = 0; exp_rw = 0;
        step(1, 1, 7, 8'hAA, 7, "reset1");
        step(1, 2, 3, 8'h55, 1, "reset2");
        check("reset.data_lit", int'(bus.o_Dataout), 8'h00);
        step(0, 1, 4, 5, 6, "store_reg");
        check("store_reg.addr_lit", int'(bus.o_Addressdata), 8'h04);
        step(0, 2, 4, 5, 6, "store_imm");
        check("store_imm.addr_lit", int'(bus.o_Addressdata), 8'h06);
        step(0, 0, 4, 8'hFF, 6, "idle_hold");
        check("idle_hold.data_lit", int'(bus.o_Dataout), 8'h05);
        step(0, 3, 4, 5, 6, "load");
        check("load.addr_lit", int'(bus.o_Addressdata), 8'h26);
        step(0, 0, 1, 8'h12, 2, "idle_after_load");
        step(0, 3, 7, 8'hFF, 7, "load_max");
        step(0, 1, 7, 8'hFF, 0, "store_reg_max");
        step(0, 2, 0, 8'h80, 7, "store_imm_max");
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < 4; s++)
                step(0, s, 4, 5 + r, 6, "cycle");
        step(1, 1, 4, 5, 6, "mid_reset");
        step(0, 1, 4, 5, 6, "post_reset_reg");
        step(0, 2, 4, 5, 6, "post_reset_imm");
        step(0, 3, 4, 5, 6, "post_reset_load");
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 19) == 0) ? 1 : 0, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 7)), "random");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
